// File: rtl/encoder_8to3_serial.sv
// Serial 8-to-3 encoder: emits one 3-bit index per set bit of an accepted
// vector, in priority order, over a valid/ready output stream.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_y          request vector to encode
//   i_in_valid   i_y is valid this cycle
//   o_in_ready   block can accept a new vector
//   o_x          index of the current set bit
//   o_out_valid  o_x is valid
//   i_out_ready  consumer accepts o_x this cycle
//   o_out_last   o_x is the final index of the current vector
//   o_zero_err   one-cycle pulse after an all-zero vector is accepted
module encoder_8to3_serial #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_y,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [2:0] o_x,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_zero_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_pend;
  logic       r_zero_err;

  state_t     w_state_nxt;
  logic [7:0] w_pend_nxt;
  logic       w_zero_nxt;
  logic [2:0] w_idx;
  logic       w_one_hot;

  // Priority pick: the last match in the scan order wins, so the scan
  // direction is the reverse of the desired priority.
  always_comb begin
    w_idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (r_pend[i]) w_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (r_pend[i]) w_idx = 3'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
  assign w_one_hot = (r_pend != 8'd0) &&
                     ((r_pend & (r_pend - 8'd1)) == 8'd0);

  assign o_in_ready  = (r_state == IDLE) && !i_reset;
  assign o_out_valid = (r_state == BUSY);
  assign o_x         = o_out_valid ? w_idx : 3'd0;
  assign o_out_last  = o_out_valid && w_one_hot;
  assign o_zero_err  = r_zero_err;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_zero_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_in_valid && o_in_ready) begin
          if (i_y != 8'd0) begin
            w_pend_nxt  = i_y;
            w_state_nxt = BUSY;
          end else begin
            w_zero_nxt = 1'b1;
          end
        end
      end
      BUSY: begin
        if (i_out_ready) begin
          if (o_out_last) begin
            w_pend_nxt  = 8'd0;
            w_state_nxt = IDLE;
          end else begin
            w_pend_nxt[w_idx] = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_pend     <= 8'd0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_zero_err <= w_zero_nxt;
    end
  end

endmodule
